// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter: control logic drives the
// master side, the counter implements the slave side.
interface updown_mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic             UP;
  logic             LOAD;
  logic [WIDTH-1:0] DATA;
  logic             CLR;
  logic [WIDTH-1:0] COUNT;
  logic             TC;
  logic             OVF;

  modport master (
    output EN, UP, LOAD, DATA, CLR,
    input  COUNT, TC, OVF
  );

  modport slave (
    input  EN, UP, LOAD, DATA, CLR,
    output COUNT, TC, OVF
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Programmable-width, programmable-modulus up/down counter with prescaler,
// wrap-or-saturate bounds, registered terminal-count pulse and sticky overflow.
module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MOD_MAX  = 2**WIDTH - 1,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  updown_mod_counter_if.slave  bus
);

  localparam int               PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MOD_MAX_C = WIDTH'(MOD_MAX);
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};
  localparam logic [PS_W-1:0]  PS_ZERO   = {PS_W{1'b0}};

  logic [WIDTH-1:0] count_r;
  logic [PS_W-1:0]  ps_r;
  logic             tc_r;
  logic             ovf_r;

  logic [WIDTH-1:0] count_next_s;
  logic [PS_W-1:0]  ps_next_s;
  logic             tc_next_s;
  logic             ovf_next_s;
  logic             step_s;

  // Out-of-range load values are clamped to the modulus bound.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
    if (value > MOD_MAX_C) begin
      clamp_load = MOD_MAX_C;
    end else begin
      clamp_load = value;
    end
  endfunction

  assign step_s = bus.EN && (ps_r == PS_LAST);

  // Next-state: CLR beats LOAD beats a step; a bound hit raises TC and OVF.
  always_comb begin
    count_next_s = count_r;
    ps_next_s    = ps_r;
    tc_next_s    = 1'b0;
    ovf_next_s   = ovf_r;
    if (bus.CLR) begin
      count_next_s = ZERO_C;
      ps_next_s    = PS_ZERO;
      ovf_next_s   = 1'b0;
    end else if (bus.LOAD) begin
      count_next_s = clamp_load(bus.DATA);
      ps_next_s    = PS_ZERO;
    end else if (step_s) begin
      ps_next_s = PS_ZERO;
      if (bus.UP) begin
        if (count_r >= MOD_MAX_C) begin
          count_next_s = SATURATE ? MOD_MAX_C : ZERO_C;
          tc_next_s    = 1'b1;
          ovf_next_s   = 1'b1;
        end else begin
          count_next_s = count_r + WIDTH'(1);
        end
      end else begin
        if (count_r == ZERO_C) begin
          count_next_s = SATURATE ? ZERO_C : MOD_MAX_C;
          tc_next_s    = 1'b1;
          ovf_next_s   = 1'b1;
        end else begin
          count_next_s = count_r - WIDTH'(1);
        end
      end
    end else if (bus.EN) begin
      ps_next_s = ps_r + PS_W'(1);
    end else begin
      ps_next_s = ps_r;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_r <= ZERO_C;
      ps_r    <= PS_ZERO;
      tc_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= count_next_s;
      ps_r    <= ps_next_s;
      tc_r    <= tc_next_s;
      ovf_r   <= ovf_next_s;
    end
  end

  assign bus.COUNT = count_r;
  assign bus.TC    = tc_r;
  assign bus.OVF   = ovf_r;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: four parameterisations driven from a
// vector table plus hand-written reset and prescaler sequences.
module tb_updown_mod_counter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  // A: 8-bit wrap, B: 4-bit mod 9 saturate, C: 8-bit prescale 3, D: 4-bit mod 9 wrap
  updown_mod_counter_if #(.WIDTH(8)) ia ();
  updown_mod_counter_if #(.WIDTH(4)) ib ();
  updown_mod_counter_if #(.WIDTH(8)) ic ();
  updown_mod_counter_if #(.WIDTH(4)) id ();

  updown_mod_counter #(.WIDTH(8)) dut_a (.CLK(clk), .RST(rst_n), .bus(ia));
  updown_mod_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1'b1)) dut_b (.CLK(clk), .RST(rst_n), .bus(ib));
  updown_mod_counter #(.WIDTH(8), .PRESCALE(3)) dut_c (.CLK(clk), .RST(rst_n), .bus(ic));
  updown_mod_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1'b0)) dut_d (.CLK(clk), .RST(rst_n), .bus(id));

  typedef struct {
    int         sel;
    bit         en;
    bit         up;
    bit         load;
    bit         clr;
    logic [7:0] data;
    logic [7:0] exp_count;
    bit         exp_tc;
    bit         exp_ovf;
    string      name;
  } vec_t;

  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  function automatic vec_t mk(input int sel, input bit en, input bit up, input bit load,
                              input bit clr, input logic [7:0] data, input logic [7:0] exp_count,
                              input bit exp_tc, input bit exp_ovf, input string name);
    vec_t v;
    v.sel = sel; v.en = en; v.up = up; v.load = load; v.clr = clr; v.data = data;
    v.exp_count = exp_count; v.exp_tc = exp_tc; v.exp_ovf = exp_ovf; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ctrl(input int sel, input bit en, input bit up, input bit load,
                          input bit clr, input logic [7:0] data);
    ia.EN = 1'b0; ia.UP = 1'b0; ia.LOAD = 1'b0; ia.CLR = 1'b0; ia.DATA = 8'h00;
    ib.EN = 1'b0; ib.UP = 1'b0; ib.LOAD = 1'b0; ib.CLR = 1'b0; ib.DATA = 4'h0;
    ic.EN = 1'b0; ic.UP = 1'b0; ic.LOAD = 1'b0; ic.CLR = 1'b0; ic.DATA = 8'h00;
    id.EN = 1'b0; id.UP = 1'b0; id.LOAD = 1'b0; id.CLR = 1'b0; id.DATA = 4'h0;
    case (sel)
      0: begin ia.EN = en; ia.UP = up; ia.LOAD = load; ia.CLR = clr; ia.DATA = data; end
      1: begin ib.EN = en; ib.UP = up; ib.LOAD = load; ib.CLR = clr; ib.DATA = data[3:0]; end
      2: begin ic.EN = en; ic.UP = up; ic.LOAD = load; ic.CLR = clr; ic.DATA = data; end
      default: begin id.EN = en; id.UP = up; id.LOAD = load; id.CLR = clr; id.DATA = data[3:0]; end
    endcase
  endtask

  task automatic check_dut(input int sel, input string name, input logic [7:0] exp_count,
                           input bit exp_tc, input bit exp_ovf);
    logic [7:0] cnt;
    logic       tc;
    logic       ovf;
    case (sel)
      0: begin cnt = ia.COUNT; tc = ia.TC; ovf = ia.OVF; end
      1: begin cnt = {4'h0, ib.COUNT}; tc = ib.TC; ovf = ib.OVF; end
      2: begin cnt = ic.COUNT; tc = ic.TC; ovf = ic.OVF; end
      default: begin cnt = {4'h0, id.COUNT}; tc = id.TC; ovf = id.OVF; end
    endcase
    check({name, ".count"}, cnt, exp_count);
    check({name, ".tc"}, {7'h00, tc}, {7'h00, exp_tc});
    check({name, ".ovf"}, {7'h00, ovf}, {7'h00, exp_ovf});
  endtask

  task automatic apply(input vec_t v);
    set_ctrl(v.sel, v.en, v.up, v.load, v.clr, v.data);
    @(posedge clk);
    #1;
    check_dut(v.sel, v.name, v.exp_count, v.exp_tc, v.exp_ovf);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set_ctrl(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) check_dut(s, "reset_state", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle with OVF set and COUNT=0x37
    apply(mk(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, "rst_prep_load"));
    apply(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, "rst_prep_wrap"));
    apply(mk(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h37, 8'h37, 1'b0, 1'b1, "rst_prep_37"));
    set_ctrl(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_dut(0, "rst_async", 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_dut(0, "rst_hold", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_dut(0, "rst_resume", 8'h01, 1'b0, 1'b0);

    // DUT A: wrap up/down, hold, LOAD on boundary step, CLR over LOAD
    tbl.push_back(mk(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFE, 8'hFE, 1'b0, 1'b0, "a_load_fe"));
    tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, "a_up_ff"));
    tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, "a_wrap_00"));
    tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, "a_up_01"));
    tbl.push_back(mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "a_down_00"));
    tbl.push_back(mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, "a_wrap_dn"));
    tbl.push_back(mk(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, "a_hold"));
    tbl.push_back(mk(0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h37, 8'h37, 1'b0, 1'b1, "a_load_boundary"));
    tbl.push_back(mk(0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 1'b0, "a_clr_load"));
    tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, "a_after_clr"));
    // DUT B: clamp then 11 down steps, saturating at 0
    tbl.push_back(mk(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd12, 8'd9, 1'b0, 1'b0, "b_load_clamp"));
    for (int i = 1; i <= 9; i++)
      tbl.push_back(mk(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'(9 - i), 1'b0, 1'b0, "b_down"));
    tbl.push_back(mk(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b1, "b_sat0_1"));
    tbl.push_back(mk(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b1, "b_sat0_2"));
    tbl.push_back(mk(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1, "b_idle"));
    tbl.push_back(mk(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd9, 8'd9, 1'b0, 1'b1, "b_load9"));
    tbl.push_back(mk(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd9, 1'b1, 1'b1, "b_sat_max"));
    // DUT C: prescale 3, EN low for 2 cycles after the 4th enabled cycle
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, "c_en1"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, "c_en2"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0, "c_en3"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0, "c_en4"));
    tbl.push_back(mk(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0, "c_off1"));
    tbl.push_back(mk(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0, "c_off2"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0, "c_en5"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd2, 1'b0, 1'b0, "c_en6"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd2, 1'b0, 1'b0, "c_en7"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd2, 1'b0, 1'b0, "c_en8"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd3, 1'b0, 1'b0, "c_en9"));
    // LOAD discards a partial prescale
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd3, 1'b0, 1'b0, "c_ps1"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd3, 1'b0, 1'b0, "c_ps2"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b1, 1'b0, 8'd10, 8'd10, 1'b0, 1'b0, "c_load_step"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd10, 1'b0, 1'b0, "c_ld_en1"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd10, 1'b0, 1'b0, "c_ld_en2"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd11, 1'b0, 1'b0, "c_ld_en3"));
    // CLR discards a partial prescale
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd11, 1'b0, 1'b0, "c_cl_pre1"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd11, 1'b0, 1'b0, "c_cl_pre2"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'd0, 1'b0, 1'b0, "c_clr"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, "c_cl_en1"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, "c_cl_en2"));
    tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0, "c_cl_en3"));
    // DUT D: wrap down from 0 to MOD_MAX, then wrap up
    tbl.push_back(mk(3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'd9, 1'b1, 1'b1, "d_wrap_dn"));
    tbl.push_back(mk(3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd9, 1'b0, 1'b1, "d_hold"));
    tbl.push_back(mk(3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b1, "d_wrap_up"));
    tbl.push_back(mk(3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd1, 1'b0, 1'b1, "d_up1"));

    foreach (tbl[i]) apply(tbl[i]);

    // Reset in the middle of a prescale period discards the partial count
    apply(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0, "c_rs_pre1"));
    apply(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0, "c_rs_pre2"));
    pulse_reset();
    apply(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, "c_rs_en1"));
    apply(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, "c_rs_en2"));
    apply(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0, "c_rs_en3"));

    set_ctrl(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
